led_fade_pwm: RTL and testbench
===============================

// Module: led_fade_pwm
// PURPOSE
//   Downstream stage of the 4-LED sequencer: its led[3:0] output (active-low) feeds led_in.
//   - Converts each hard on/off request into a PWM-driven soft fade (breathing edge).
//   - Drives the board LED pins with active-low PWM.
//   - Single clock domain. led_in is already registered in clk, so no synchronizer.
// PARAMETERS
//   PWM_PERIOD   1000  clocks per PWM frame (50 kHz at 50 MHz); also the duty full-scale
//   DUTY_INC     4     duty change per ramp tick, in clocks of on-time
//   STEP_FRAMES  50    PWM frames per ramp tick
//   - Defaults give a full fade of 250 ticks = 12.5M cycles = 0.25 s.
// PORTS
//   clk       in   1  system clock
//   rst_n     in   1  asynchronous active-low reset
//   led_in    in   4  per-LED request, 0 = on, 1 = off
//   led_out   out  4  PWM LED drive, active-low, registered
//   fading    out  4  per LED: 1 while duty != target, registered
// BEHAVIOUR
//   Interface: one clock (clk); reset rst_n is asynchronous, active-low.
//   Reset values: all counters 0; duty[i] = 0; led_out = 4'b1111; fading = 4'b0000.
//   Frame counter cnt_pwm:
//     - Counts 0..PWM_PERIOD-1 every cycle and wraps.
//     - end_pwm = (cnt_pwm == PWM_PERIOD-1).
//   Step counter cnt_step:
//     - Advances only on end_pwm; counts 0..STEP_FRAMES-1.
//     - ramp_tick = end_pwm && cnt_step == STEP_FRAMES-1.
//   Target: tgt[i] = (led_in[i] == 0) ? PWM_PERIOD : 0. led_in is sampled only on ramp_tick.
//   Duty update on ramp_tick:
//     - duty < tgt: duty <= min(duty + DUTY_INC, tgt).
//     - duty > tgt: duty <= max(duty - DUTY_INC, 0).
//     - duty == tgt: hold.
//     - Compare at width clog2(PWM_PERIOD+1)+1 so the saturating step never wraps.
//   Glitch-free: duty changes only at a frame boundary, so every frame runs one constant duty.
//   Compare:
//     - led_out[i] <= ~(cnt_pwm < duty[i]).
//     - Latency 1 clk from cnt_pwm to pin.
//     - Each frame is low for exactly duty[i] cycles.
//     - duty = 0 gives a constant 1 (off); duty = PWM_PERIOD gives a constant 0 (on).
//   fading[i] <= (duty[i] != tgt(led_in[i])), evaluated every cycle.
//   Reversal: if led_in toggles mid-fade, the next ramp_tick steps from the current duty.
//     No restart, no jump.
//   Toggles between ramp ticks are ignored; only the value present at ramp_tick counts.
//   Reset mid-fade: immediate async return to the reset values above; all LEDs off.
// CONFIGURATION
//   Macro LED_PWM_STAGGER_EN.
//   - Defined: channel i compares (cnt_pwm + i*(PWM_PERIOD/4)) mod PWM_PERIOD against duty[i].
//     On-time per frame is unchanged; the four LED edges are phase-spread to cut peak current.
//   - Undefined: all channels compare raw cnt_pwm, so all LEDs turn on at cnt_pwm == 0.
// STRUCTURE
//   Package led_pwm_pkg:
//     - LED_NUM = 4; LED_ON = 1'b0; LED_OFF = 1'b1.
//     - Function duty_w(period) returns clog2(period+1).
//   Top level holds cnt_pwm, cnt_step and ramp_tick (shared by all channels).
//   Sub-module led_pwm_chan, instantiated LED_NUM times:
//     - Inputs: cnt_pwm, ramp_tick, req.
//     - Contains the duty register, the saturating ramp and the compare/output flop.
//     - Outputs: led_out bit and fading bit.
// TESTING  (bench params PWM_PERIOD=10, DUTY_INC=3, STEP_FRAMES=2; one ramp tick per 20 clks)
//   1. Reset: assert rst_n=0 mid-frame.
//      -> led_out=4'b1111 and fading=0 immediately; counters read 0 after release.
//   2. Fade-on: led_in=4'b1110 held.
//      -> duty[0] steps 3,6,9,10 on successive ramp ticks.
//      -> led_out[0] low for 3/6/9/10 clks per frame; fading[0] drops when duty reaches 10.
//   3. Fade-off from full: led_in[0]=1.
//      -> duty 7,4,1,0; led_out[0] constant 1 once duty reaches 0.
//   4. Mid-ramp reversal: switch led_in[0] 0->1 when duty=6.
//      -> following ticks give 3, then 0; no jump to 10 or 0.
//   5. Short pulse: led_in[1] low for 5 clks, not spanning a ramp_tick.
//      -> duty[1] stays 0, fading[1] pulses high for 5 clks, led_out[1] stays 1.
//   6. With LED_PWM_STAGGER_EN, all LEDs at duty 10->5.
//      -> each led_out low 5 clks per frame, channel i falling edge offset by i*2 clks.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared constants and width helpers for the LED fade PWM stage.
package led_pwm_pkg;

   localparam int unsigned LED_NUM = 4;
   localparam logic        LED_ON  = 1'b0;
   localparam logic        LED_OFF = 1'b1;

   typedef logic [LED_NUM-1:0] led_vec_t;

   // Bits needed to hold a duty value in 0..period inclusive.
   function automatic int unsigned duty_w(input int unsigned period);
      return $clog2(period + 1);
   endfunction

   // Bits needed for a counter running 0..period-1.
   function automatic int unsigned cnt_w(input int unsigned period);
      return (period > 1) ? $clog2(period) : 1;
   endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: duty register, saturating ramp toward the request target,
// and the registered PWM compare driving the active-low pin.
module led_pwm_chan
   import led_pwm_pkg::*;
#(
   parameter int unsigned PWM_PERIOD = 1000,
   parameter int unsigned DUTY_INC   = 4,
   parameter int unsigned PHASE      = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [cnt_w(PWM_PERIOD)-1:0] i_cnt_pwm,
   input  logic                         i_ramp_tick,
   input  logic                         i_req,
   output logic                         o_led,
   output logic                         o_fading
);

   localparam int unsigned   DW   = duty_w(PWM_PERIOD);
   // One spare bit so duty + DUTY_INC and cnt + PHASE never wrap.
   localparam int unsigned   CW   = DW + 1;
   localparam logic [CW-1:0] FULL = CW'(PWM_PERIOD);
   localparam logic [CW-1:0] INC  = CW'(DUTY_INC);
   localparam logic [CW-1:0] OFS  = CW'(PHASE % PWM_PERIOD);

   logic [DW-1:0] r_duty;
   logic          r_led;
   logic          r_fading;

   logic [CW-1:0] w_duty;
   logic [CW-1:0] w_tgt;
   logic [CW-1:0] w_up;
   logic [CW-1:0] w_next;
   logic [CW-1:0] w_sum;
   logic [CW-1:0] w_pos;

   assign w_duty = CW'(r_duty);
   assign w_tgt  = (i_req == LED_ON) ? FULL : '0;
   assign w_up   = w_duty + INC;

   always_comb begin
      w_next = w_duty;
      if (w_duty < w_tgt) begin
         w_next = (w_up < w_tgt) ? w_up : w_tgt;
      end else if (w_duty > w_tgt) begin
         w_next = (w_duty > INC) ? (w_duty - INC) : '0;
      end
   end

   // Phase-shifted frame position; equals i_cnt_pwm when PHASE is 0.
   assign w_sum = CW'(i_cnt_pwm) + OFS;
   assign w_pos = (w_sum >= FULL) ? (w_sum - FULL) : w_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_duty   <= '0;
         r_led    <= LED_OFF;
         r_fading <= 1'b0;
      end else begin
         if (i_ramp_tick) begin
            r_duty <= DW'(w_next);
         end
         r_led    <= ~(w_pos < w_duty);
         r_fading <= (w_duty != w_tgt);
      end
   end

   assign o_led    = r_led;
   assign o_fading = r_fading;

endmodule

// File: rtl/led_fade_pwm.sv
// Turns hard active-low LED on/off requests into PWM soft fades.
// Define LED_PWM_STAGGER_EN to phase-spread the four channels across the frame.
module led_fade_pwm
   import led_pwm_pkg::*;
#(
   parameter int unsigned PWM_PERIOD  = 1000,
   parameter int unsigned DUTY_INC    = 4,
   parameter int unsigned STEP_FRAMES = 50
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [LED_NUM-1:0] led_in,
   output logic [LED_NUM-1:0] led_out,
   output logic [LED_NUM-1:0] fading
);

   localparam int unsigned         CNT_W     = cnt_w(PWM_PERIOD);
   localparam int unsigned         STEP_W    = cnt_w(STEP_FRAMES);
   localparam logic [CNT_W-1:0]    PWM_LAST  = CNT_W'(PWM_PERIOD - 1);
   localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_FRAMES - 1);

`ifdef LED_PWM_STAGGER_EN
   localparam int unsigned PHASE_STEP = PWM_PERIOD / LED_NUM;
`else
   localparam int unsigned PHASE_STEP = 0;
`endif

   logic [CNT_W-1:0]  r_cnt_pwm;
   logic [STEP_W-1:0] r_cnt_step;
   logic              w_end_pwm;
   logic              w_ramp_tick;

   assign w_end_pwm   = (r_cnt_pwm == PWM_LAST);
   assign w_ramp_tick = w_end_pwm && (r_cnt_step == STEP_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_pwm <= '0;
      end else if (w_end_pwm) begin
         r_cnt_pwm <= '0;
      end else begin
         r_cnt_pwm <= r_cnt_pwm + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_step <= '0;
      end else if (w_end_pwm) begin
         if (r_cnt_step == STEP_LAST) begin
            r_cnt_step <= '0;
         end else begin
            r_cnt_step <= r_cnt_step + STEP_W'(1);
         end
      end
   end

   for (genvar g = 0; g < LED_NUM; g++) begin : g_chan
      led_pwm_chan #(
         .PWM_PERIOD (PWM_PERIOD),
         .DUTY_INC   (DUTY_INC),
         .PHASE      (g * PHASE_STEP)
      ) u_chan (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_cnt_pwm   (r_cnt_pwm),
         .i_ramp_tick (w_ramp_tick),
         .i_req       (led_in[g]),
         .o_led       (led_out[g]),
         .o_fading    (fading[g])
      );
   end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm: per-cycle reference model, a table of
// ramp-tick vectors, hand-written reset/short-pulse sequences and random requests.
module tb_led_fade_pwm;
   import led_pwm_pkg::*;

   localparam int P   = 10;
   localparam int INC = 3;
   localparam int SF  = 2;
   localparam int TPR = P * SF;

`ifdef LED_PWM_STAGGER_EN
   localparam int OFF = P / 4;
`else
   localparam int OFF = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] led_in;
   logic [3:0] led_out;
   logic [3:0] fading;

   always #5 clk = ~clk;

   led_fade_pwm #(
      .PWM_PERIOD  (P),
      .DUTY_INC    (INC),
      .STEP_FRAMES (SF)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .led_in  (led_in),
      .led_out (led_out),
      .fading  (fading)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: m_t counts clock edges since reset release.
   int         m_duty[4];
   int         m_t;
   logic [3:0] exp_led = 4'hF;
   logic [3:0] exp_fad = 4'h0;

   typedef struct {
      logic [3:0]      led_in;
      logic [3:0][4:0] lows;
      logic [3:0]      fad;
   } vec_t;

   vec_t vecs[14];

   function automatic void check_vec(input string name, input logic [3:0] act,
                                     input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
      end
   endfunction

   function automatic void check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_t = 0;
      for (int i = 0; i < 4; i++) m_duty[i] = 0;
      exp_led = 4'hF;
      exp_fad = 4'h0;
   endfunction

   // Outputs registered at the coming edge, then the duty step if it is a ramp tick.
   function automatic void model_edge();
      int cnt = m_t % P;
      for (int i = 0; i < 4; i++) begin
         int tgt = (led_in[i] == LED_ON) ? P : 0;
         exp_led[i] = !(((cnt + i * OFF) % P) < m_duty[i]);
         exp_fad[i] = (m_duty[i] != tgt);
      end
      if ((m_t % TPR) == TPR - 1) begin
         for (int i = 0; i < 4; i++) begin
            int tgt = (led_in[i] == LED_ON) ? P : 0;
            if (m_duty[i] < tgt) begin
               m_duty[i] = (m_duty[i] + INC < tgt) ? m_duty[i] + INC : tgt;
            end else if (m_duty[i] > tgt) begin
               m_duty[i] = (m_duty[i] > INC) ? m_duty[i] - INC : 0;
            end
         end
      end
      m_t++;
   endfunction

   // Inputs change only right after a negedge check; outputs compared at negedge.
   task automatic cycle();
      if (rst_n) model_edge();
      else model_reset();
      @(posedge clk);
      @(negedge clk);
      check_vec("led_out", led_out, exp_led);
      check_vec("fading", fading, exp_fad);
   endtask

   task automatic run_row(input int idx);
      int lows[4];
      while ((m_t % TPR) != 10) cycle();
      led_in = vecs[idx].led_in;
      repeat (10) cycle();
      for (int i = 0; i < 4; i++) lows[i] = 0;
      repeat (10) begin
         cycle();
         for (int i = 0; i < 4; i++) if (!led_out[i]) lows[i]++;
      end
      for (int i = 0; i < 4; i++) begin
         check_int($sformatf("row%0d_low_ch%0d", idx, i), lows[i], int'(vecs[idx].lows[i]));
      end
      check_vec($sformatf("row%0d_fading", idx), fading, vecs[idx].fad);
   endtask

   task automatic async_reset();
      #3 rst_n = 1'b0;
      #1;
      check_vec("rst_led_out", led_out, 4'hF);
      check_vec("rst_fading", fading, 4'h0);
      model_reset();
      @(negedge clk);
      repeat (2) cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      int fad1;
      int low1;
      int low2;

      // Ramp-tick vectors: lows[i] = clocks low per frame after the tick.
      vecs[0]  = '{led_in: 4'b1110, lows: {5'd0, 5'd0, 5'd0, 5'd3},  fad: 4'b0001};
      vecs[1]  = '{led_in: 4'b1110, lows: {5'd0, 5'd0, 5'd0, 5'd6},  fad: 4'b0001};
      vecs[2]  = '{led_in: 4'b1110, lows: {5'd0, 5'd0, 5'd0, 5'd9},  fad: 4'b0001};
      vecs[3]  = '{led_in: 4'b1110, lows: {5'd0, 5'd0, 5'd0, 5'd10}, fad: 4'b0000};
      vecs[4]  = '{led_in: 4'b1111, lows: {5'd0, 5'd0, 5'd0, 5'd7},  fad: 4'b0001};
      vecs[5]  = '{led_in: 4'b1111, lows: {5'd0, 5'd0, 5'd0, 5'd4},  fad: 4'b0001};
      vecs[6]  = '{led_in: 4'b1111, lows: {5'd0, 5'd0, 5'd0, 5'd1},  fad: 4'b0001};
      vecs[7]  = '{led_in: 4'b1111, lows: {5'd0, 5'd0, 5'd0, 5'd0},  fad: 4'b0000};
      vecs[8]  = '{led_in: 4'b1110, lows: {5'd0, 5'd0, 5'd0, 5'd3},  fad: 4'b0001};
      vecs[9]  = '{led_in: 4'b1110, lows: {5'd0, 5'd0, 5'd0, 5'd6},  fad: 4'b0001};
      vecs[10] = '{led_in: 4'b1111, lows: {5'd0, 5'd0, 5'd0, 5'd3},  fad: 4'b0001};
      vecs[11] = '{led_in: 4'b1111, lows: {5'd0, 5'd0, 5'd0, 5'd0},  fad: 4'b0000};
      vecs[12] = '{led_in: 4'b0000, lows: {5'd3, 5'd3, 5'd3, 5'd3},  fad: 4'b1111};
      vecs[13] = '{led_in: 4'b0011, lows: {5'd6, 5'd6, 5'd0, 5'd0},  fad: 4'b1100};

      rst_n  = 1'b1;
      led_in = 4'hF;
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      check_vec("por_led_out", led_out, 4'hF);
      check_vec("por_fading", fading, 4'h0);
      @(negedge clk);
      repeat (3) cycle();
      rst_n = 1'b1;

      for (int r = 0; r < 14; r++) run_row(r);

      // Short request on LED1 between ramp ticks: fading pulses, duty never moves.
      while ((m_t % TPR) != 1) cycle();
      fad1 = 0;
      low1 = 0;
      led_in[1] = LED_ON;
      repeat (5) begin
         cycle();
         if (fading[1]) fad1++;
         if (!led_out[1]) low1++;
      end
      led_in[1] = LED_OFF;
      repeat (14) begin
         cycle();
         if (fading[1]) fad1++;
         if (!led_out[1]) low1++;
      end
      check_int("pulse_fading1_clks", fad1, 5);
      check_int("pulse_led1_low_clks", low1, 0);
      low1 = 0;
      low2 = 0;
      repeat (10) begin
         cycle();
         if (!led_out[1]) low1++;
         if (!led_out[2]) low2++;
      end
      check_int("pulse_after_low_ch1", low1, 0);
      check_int("pulse_after_low_ch2", low2, 10);

      // Random requests against the model, then a reset in the middle of a fade.
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 7) == 0) led_in = 4'($urandom);
         cycle();
      end
      led_in = 4'h0;
      repeat (45) cycle();
      async_reset();
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 5) == 0) led_in = 4'($urandom);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
